rect_obuf: RTL

- Output-buffer end of the rectification pipeline; receives the interpolated-pixel burst stream (Obuf I/F) produced by the bilinear interpolator.
- Packs 8-bit pixels into 64-bit words aligned to memory byte lanes, computes the destination address per burst and issues write commands plus write data to the downstream DMA writer.
- The Obuf I/F has no backpressure, so the block buffers data and flags overflow.

---
 rtl/rect_obuf_pkg.sv | 33 +++
 rtl/rect_obuf_fifo.sv | 50 +++++
 rtl/rect_obuf.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rect_obuf_pkg.sv
// Shared widths, FIFO entry field offsets and the burst beat-count helper for rect_obuf.
package rect_obuf_pkg;

  localparam int PIX_W     = 8;
  localparam int WORD_W    = 64;
  localparam int LANES     = 8;
  localparam int LANE_W    = 3;
  localparam int LEN_W     = 7;
  localparam int CMD_LEN_W = 5;
  localparam int ADDR_W    = 32;
  localparam int MUL_W     = 25;

  // Data entry {data, strb, wr_last, frame_last}
  localparam int D_FLAST   = 0;
  localparam int D_WLAST   = 1;
  localparam int D_STRB_LO = 2;
  localparam int D_DATA_LO = D_STRB_LO + LANES;
  localparam int DENT_W    = D_DATA_LO + WORD_W;

  // Command entry {addr, len}
  localparam int C_LEN_LO  = 0;
  localparam int C_ADDR_LO = CMD_LEN_W;
  localparam int CENT_W    = C_ADDR_LO + ADDR_W;

  // Number of 64-bit beats touched by a burst starting at byte lane x0.
  function automatic logic [CMD_LEN_W-1:0] burst_beats(input logic [LANE_W-1:0] x0,
                                                       input logic [LEN_W-1:0]  len);
    logic [7:0] sum;
    sum = 8'(x0) + 8'(len) + 8'd7;
    return sum[7:3];
  endfunction

endpackage

// File: rtl/rect_obuf_fifo.sv
// Synchronous show-ahead FIFO; head is presented combinationally, zero while empty.
module rect_obuf_fifo #(
  parameter int W    = 8,
  parameter int LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         drop
);

  localparam int DEPTH = 1 << LOG2;

  logic [W-1:0]    mem [DEPTH];
  logic [LOG2-1:0] wr_ptr;
  logic [LOG2-1:0] rd_ptr;
  logic [LOG2:0]   count;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (LOG2+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (LOG2+1)'(do_push) - (LOG2+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rect_obuf.sv
// Output buffer: packs interpolated pixels into 64-bit lane-aligned words and issues DMA commands.
// Optional RECT_OBUF_STAT_EN adds pixel/command statistics counters.
module rect_obuf
  import rect_obuf_pkg::*;
#(
  parameter int DW_LOG2 = 5,
  parameter int CW_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vout,
  input  logic                 last_o,
  input  logic                 lr_o,
  input  logic [8:0]           ydst_o,
  input  logic [9:0]           xdst_o,
  input  logic [LEN_W-1:0]     len_o,
  input  logic [PIX_W-1:0]     intp,
  input  logic [ADDR_W-1:0]    base_l,
  input  logic [ADDR_W-1:0]    base_r,
  input  logic [15:0]          stride,
  input  logic                 ovf_clr,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [ADDR_W-1:0]    cmd_addr,
  output logic [CMD_LEN_W-1:0] cmd_len,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [WORD_W-1:0]    wr_data,
  output logic [LANES-1:0]     wr_strb,
  output logic                 wr_last,
  output logic                 done,
  output logic                 ovf
`ifdef RECT_OBUF_STAT_EN
  ,
  output logic [23:0]          stat_pix,
  output logic [15:0]          stat_burst
`endif
);

  logic [LEN_W-1:0]  cnt;
  logic [LANE_W-1:0] lane;
  logic              flast_hdr;
  logic [WORD_W-1:0] pack_data;
  logic [LANES-1:0]  pack_strb;

  logic              start;
  logic              beat;
  logic              burst_end;
  logic              word_end;
  logic [LANE_W-1:0] cur_lane;
  logic              cur_flast;
  logic [WORD_W-1:0] nxt_data;
  logic [LANES-1:0]  nxt_strb;

  logic              wvld_p1;
  logic [DENT_W-1:0] went_p1;
  logic              cvld_p1;
  logic [ADDR_W-1:0] base_p1;
  logic [MUL_W-1:0]  mul_p1;
  logic [9:0]        xoff_p1;
  logic [CMD_LEN_W-1:0] clen_p1;
  logic [CENT_W-1:0] cent_p1;

  logic [DENT_W-1:0] whead;
  logic [CENT_W-1:0] chead;
  logic              d_empty;
  logic              c_empty;
  logic              d_drop;
  logic              c_drop;

  // ---- stage p0: pixel beat into the pack registers
  always_comb begin
    start     = vout && (cnt == '0) && (len_o != '0);
    beat      = start || (vout && (cnt != '0));
    cur_lane  = start ? xdst_o[2:0] : lane;
    cur_flast = start ? last_o : flast_hdr;
    burst_end = beat && (start ? (len_o == 7'd1) : (cnt == 7'd1));
    word_end  = beat && ((cur_lane == 3'd7) || burst_end);
    nxt_data  = pack_data;
    nxt_strb  = pack_strb;
    if (beat) begin
      nxt_data[{cur_lane, 3'b000} +: PIX_W] = intp;
      nxt_strb[cur_lane]                    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lane      <= '0;
      flast_hdr <= 1'b0;
      pack_data <= '0;
      pack_strb <= '0;
      wvld_p1   <= 1'b0;
      cvld_p1   <= 1'b0;
    end else begin
      wvld_p1 <= word_end;
      cvld_p1 <= start;
      if (beat) begin
        cnt  <= start ? (len_o - 7'd1) : (cnt - 7'd1);
        lane <= cur_lane + 3'd1;
      end
      if (start) flast_hdr <= last_o;
      // Completed words leave through went_p1; the pack registers restart empty.
      if (word_end) begin
        pack_data <= '0;
        pack_strb <= '0;
      end else if (beat) begin
        pack_data <= nxt_data;
        pack_strb <= nxt_strb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_end) went_p1 <= {nxt_data, nxt_strb, burst_end, cur_flast};
    if (start) begin
      base_p1 <= lr_o ? base_r : base_l;
      mul_p1  <= ydst_o * stride;
      xoff_p1 <= {xdst_o[9:3], 3'b000};
      clen_p1 <= burst_beats(xdst_o[2:0], len_o);
    end
  end

  // ---- stage p1: address sum and FIFO pushes
  assign cent_p1 = {base_p1 + ADDR_W'(mul_p1) + ADDR_W'(xoff_p1), clen_p1};

  rect_obuf_fifo #(.W(DENT_W), .LOG2(DW_LOG2)) u_dfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wvld_p1),
    .wdata (went_p1),
    .pop   (wr_ready),
    .rdata (whead),
    .empty (d_empty),
    .drop  (d_drop)
  );

  rect_obuf_fifo #(.W(CENT_W), .LOG2(CW_LOG2)) u_cfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cvld_p1),
    .wdata (cent_p1),
    .pop   (cmd_ready),
    .rdata (chead),
    .empty (c_empty),
    .drop  (c_drop)
  );

  assign cmd_valid = ~c_empty;
  assign cmd_addr  = chead[C_ADDR_LO +: ADDR_W];
  assign cmd_len   = chead[C_LEN_LO +: CMD_LEN_W];
  assign wr_valid  = ~d_empty;
  assign wr_data   = whead[D_DATA_LO +: WORD_W];
  assign wr_strb   = whead[D_STRB_LO +: LANES];
  assign wr_last   = whead[D_WLAST];

  // ---- stage p2: frame completion and overflow flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= wr_valid & wr_ready & wr_last & whead[D_FLAST];
      if (d_drop | c_drop) ovf <= 1'b1;
      else if (ovf_clr)    ovf <= 1'b0;
    end
  end

`ifdef RECT_OBUF_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pix   <= '0;
      stat_burst <= '0;
    end else if (done) begin
      stat_pix   <= '0;
      stat_burst <= '0;
    end else begin
      if (beat)                  stat_pix   <= stat_pix + 24'd1;
      if (cmd_valid & cmd_ready) stat_burst <= stat_burst + 16'd1;
    end
  end
`endif

endmodule
